top_level: RTL and testbench
============================

Name: top_level

Overview:
- Self-contained "program 3" engine: scans a 32-byte message held in an internal data memory for a 5-bit pattern.
- Computes three match counts and writes them back into that memory.
- Pulsing reset starts a run; `done` flags completion.
- The bench preloads and inspects memory hierarchically through instance `dm1`, array `core`.

Parameters:
- MSG_BYTES, 32, message length in bytes (addresses 0..MSG_BYTES-1).
- PAT_ADDR, 32, address of the pattern byte; pattern is bits [7:3].
- RES_ADDR, 33, first result address; results go to RES_ADDR, +1, +2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset; a pulse starts a new run.
- done  output  1  high when all results are written; held until next reset.

Behaviour:
- Memory:
  - Sub-instance `dm1` contains array `core`, 256 x 8 bits.
  - Combinational read; synchronous write.
  - Contents are not cleared by reset; the bench preloads it before the run.
- Pattern: `pat` = `core[32][7:3]`.
- Message bit order: byte 0 is the most significant byte of a 256-bit string; within each byte, bit 7 comes first.
- Result definitions, all 8-bit:
  - `ctb` = over bytes 0..31, number of windows among b[4:0], b[5:1], b[6:2], b[7:3] equal to `pat` (max 128).
  - `cto` = number of bytes with at least one such in-byte match (max 32).
  - `cts` = over all 252 five-bit windows of the 256-bit string, number equal to `pat` (max 252).
  - Implementation: `cts` = `ctb` + straddling matches. For i = 0..30, let x = {b[i][3:0], b[i+1][7:4]}; count x[7:3], x[6:2], x[5:1], x[4:0] equal to `pat`.
  - No overflow is possible; counters are 8 bits.
- FSM, clk domain:
  - INIT: latch `pat` from addr 32; clear counters and the previous-byte register.
  - SCAN: one byte per cycle, i = 0..31. Update `ctb`/`cto` from byte i. If i > 0, add straddling matches between prev and byte i. Store byte i in prev.
  - WR0, WR1, WR2: write `ctb`→33, `cto`→34, `cts`→35, one per cycle.
  - DONE: `done` = 1; hold until reset.
- Latency: `done` rises 36 rising edges after reset deasserts (1 INIT + 32 SCAN + 3 WR); it is registered.
- Reset state: FSM in INIT, counters 0, `done` = 0.
- Reset asserted mid-run, asynchronously:
  - Immediately returns to INIT with `done` low.
  - Result bytes already written stay until overwritten.
  - After release, a full run is performed on the current memory contents.
- No writes to addresses other than 33..35 (36 only with the option below).
- Addresses 0..32 are read-only during a run.

Optional Feature:
- CYCLE_COUNT_EN defined:
  - An 8-bit counter counts cycles from reset release to entry into DONE (value 36).
  - It is written to `core[36]` in an extra WR3 state, so `done` latency becomes 37.
- Undefined: no counter, no write to 36, latency 36.

Decomposition:
- Package `prog3_pkg`:
  - state enum (INIT, SCAN, WR0, WR1, WR2, WR3, DONE);
  - address constants PAT_ADDR, RES_ADDR, MSG_BYTES;
  - function `match4(byte8, pat5)` returning the 0..4 count of its four windows.
- Sub-module `data_mem` (instance `dm1`) holds `core[256]`, with ports clk, wr_en, addr, wr_data, rd_data.
- Counting and FSM stay in `top_level`.

Test Plan:
- All bytes 0x55, `pat` = 10101 → `core[33]` = 64, `core[34]` = 32, `core[35]` = 126; `done` after 36 cycles.
- All bytes 0x00, `pat` = 00000 → 128, 32, 252.
- All bytes 0xFF, `pat` = 00000 → 0, 0, 0.
- `core[0]` = 0xF8, rest 0x00:
  - `pat` = 11111 → 1, 1, 1;
  - `pat` = 00000 → 124, 31, 247.
- Random bytes and `pat` (20 seeds) → match a bench golden model of `ctb`/`cto`/`cts`; addresses 0..32 unchanged.
- Reset reasserted 10 cycles into SCAN → `done` drops immediately; after release, a full 36-cycle run gives correct results.

Source files
------------

// File: rtl/prog3_pkg.sv
// rtl/prog3_pkg.sv - shared state encoding, address map and window-match helper for the program 3 engine
package prog3_pkg;

  typedef enum logic [2:0] {INIT, SCAN, WR0, WR1, WR2, WR3, DONE} state_t;

  localparam int         MSG_BYTES = 32;
  localparam logic [7:0] PAT_ADDR  = 8'd32;
  localparam logic [7:0] RES_ADDR  = 8'd33;

  // Count how many of the four 5-bit windows of an 8-bit value equal the pattern
  function automatic logic [2:0] match4(input logic [7:0] byte8, input logic [4:0] pat5);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (byte8[k +: 5] == pat5) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - 256x8 data memory, combinational read, synchronous write, never cleared by reset
module data_mem (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data
);

  logic [7:0] core [0:255];

  // Synchronous write port; contents survive reset so a preloaded message is kept
  always_ff @(posedge clk) begin
    if (wr_en) core[addr] <= wr_data;
  end

  assign rd_data = core[addr];

endmodule

// File: rtl/top_level.sv
// rtl/top_level.sv - pattern-count engine over a 32-byte message; CYCLE_COUNT_EN adds a cycle count written to address 36
module top_level (
  input  logic clk,
  input  logic reset,
  output logic done
);
  import prog3_pkg::*;

  state_t     state;
  logic [4:0] pat;
  logic [4:0] idx;
  logic [7:0] prev;
  logic [7:0] ctb;
  logic [7:0] cto;
  logic [7:0] cts;

  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [2:0] m_in;
  logic [2:0] m_st;

`ifdef CYCLE_COUNT_EN
  logic [7:0] cyc_cnt;
`endif

  data_mem dm1 (
    .clk     (clk),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  // Memory port steering: pattern in INIT, message byte in SCAN, one result per WR state
  always_comb begin
    wr_en   = 1'b0;
    addr    = PAT_ADDR;
    wr_data = ctb;
    case (state)
      SCAN: addr = {3'b000, idx};
      WR0: begin
        wr_en   = 1'b1;
        addr    = RES_ADDR;
        wr_data = ctb;
      end
      WR1: begin
        wr_en   = 1'b1;
        addr    = RES_ADDR + 8'd1;
        wr_data = cto;
      end
      WR2: begin
        wr_en   = 1'b1;
        addr    = RES_ADDR + 8'd2;
        wr_data = cts;
      end
`ifdef CYCLE_COUNT_EN
      WR3: begin
        wr_en   = 1'b1;
        addr    = RES_ADDR + 8'd3;
        wr_data = cyc_cnt;
      end
`endif
      default: ;
    endcase
  end

  // In-byte matches of the current byte, and matches straddling the previous/current byte boundary
  always_comb begin
    m_in = match4(rd_data, pat);
    m_st = match4({prev[3:0], rd_data[7:4]}, pat);
  end

  // Run sequencer: latch pattern, scan one byte per cycle, write results, then hold done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      pat   <= 5'd0;
      idx   <= 5'd0;
      prev  <= 8'd0;
      ctb   <= 8'd0;
      cto   <= 8'd0;
      cts   <= 8'd0;
      done  <= 1'b0;
`ifdef CYCLE_COUNT_EN
      cyc_cnt <= 8'd0;
`endif
    end else begin
`ifdef CYCLE_COUNT_EN
      if (state != DONE) cyc_cnt <= cyc_cnt + 8'd1;
`endif
      case (state)
        INIT: begin
          pat   <= rd_data[7:3];
          idx   <= 5'd0;
          prev  <= 8'd0;
          ctb   <= 8'd0;
          cto   <= 8'd0;
          cts   <= 8'd0;
          state <= SCAN;
        end
        SCAN: begin
          ctb  <= ctb + {5'b00000, m_in};
          cto  <= cto + ((m_in != 3'd0) ? 8'd1 : 8'd0);
          cts  <= cts + {5'b00000, m_in} + ((idx != 5'd0) ? {5'b00000, m_st} : 8'd0);
          prev <= rd_data;
          idx  <= idx + 5'd1;
          if (idx == 5'(MSG_BYTES - 1)) state <= WR0;
        end
        WR0: state <= WR1;
        WR1: state <= WR2;
`ifdef CYCLE_COUNT_EN
        WR2: state <= WR3;
        WR3: begin
          state <= DONE;
          done  <= 1'b1;
        end
`else
        WR2: begin
          state <= DONE;
          done  <= 1'b1;
        end
`endif
        DONE: done <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level.sv
// tb/tb_top_level.sv - self-checking bench: directed vector table, randomized runs against a bit-string model, mid-run reset
module tb_top_level;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  always #5 clk = ~clk;

`ifdef CYCLE_COUNT_EN
  localparam int LAT = 37;
`else
  localparam int LAT = 36;
`endif

  typedef struct {
    logic [7:0] fill;
    logic [7:0] b0;
    logic [4:0] pat;
    int         e_ctb;
    int         e_cto;
    int         e_cts;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] msg [0:31];
  logic [4:0] pat;
  logic [7:0] pat_byte;
  int         m_ctb, m_cto, m_cts;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: treat the message as one 256-bit MSB-first string and slide a 5-bit window over it
  task automatic model();
    logic [255:0] s;
    bit           hit [32];
    m_ctb = 0; m_cto = 0; m_cts = 0;
    for (int i = 0; i < 32; i++) begin
      s[255 - 8*i -: 8] = msg[i];
      hit[i] = 1'b0;
    end
    for (int j = 0; j < 252; j++) begin
      if (s[255 - j -: 5] == pat) begin
        m_cts++;
        if ((j % 8) <= 3) begin
          m_ctb++;
          hit[j / 8] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 32; i++) if (hit[i]) m_cto++;
  endtask

  task automatic load_mem();
    logic [2:0] junk;
    junk = 3'($urandom);
    pat_byte = {pat, junk};
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = msg[i];
    dut.dm1.core[32] = pat_byte;
    for (int a = 33; a < 37; a++) dut.dm1.core[a] = 8'hEE;
  endtask

  task automatic run(input string name, input int e_ctb, input int e_cto, input int e_cts);
    int lat;
    int diffs;
    reset = 1'b1;
    load_mem();
    @(negedge clk);
    chk($sformatf("%s reset_done", name), int'(done), 0);
    reset = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (done) lat = c;
    end
    chk($sformatf("%s latency", name), lat, LAT);
    repeat (5) @(posedge clk);
    #1;
    chk($sformatf("%s done_held", name), int'(done), 1);
    chk($sformatf("%s ctb", name), int'(dut.dm1.core[33]), e_ctb);
    chk($sformatf("%s cto", name), int'(dut.dm1.core[34]), e_cto);
    chk($sformatf("%s cts", name), int'(dut.dm1.core[35]), e_cts);
`ifdef CYCLE_COUNT_EN
    chk($sformatf("%s cycles", name), int'(dut.dm1.core[36]), 36);
`else
    chk($sformatf("%s addr36_untouched", name), int'(dut.dm1.core[36]), 8'hEE);
`endif
    diffs = 0;
    for (int i = 0; i < 32; i++) if (dut.dm1.core[i] !== msg[i]) diffs++;
    if (dut.dm1.core[32] !== pat_byte) diffs++;
    chk($sformatf("%s msg_unchanged", name), diffs, 0);
  endtask

  task automatic randomize_msg();
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    pat = 5'($urandom);
  endtask

  initial begin
    vecs[0] = '{8'h55, 8'h55, 5'b10101,  64, 32, 126};
    vecs[1] = '{8'h00, 8'h00, 5'b00000, 128, 32, 252};
    vecs[2] = '{8'hFF, 8'hFF, 5'b00000,   0,  0,   0};
    vecs[3] = '{8'h00, 8'hF8, 5'b11111,   1,  1,   1};
    vecs[4] = '{8'h00, 8'hF8, 5'b00000, 124, 31, 247};

    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 32; i++) msg[i] = vecs[v].fill;
      msg[0] = vecs[v].b0;
      pat = vecs[v].pat;
      run($sformatf("vec%0d", v), vecs[v].e_ctb, vecs[v].e_cto, vecs[v].e_cts);
    end

    for (int r = 0; r < 20; r++) begin
      randomize_msg();
      model();
      run($sformatf("rand%0d", r), m_ctb, m_cto, m_cts);
    end

    // Asynchronous reset while done is high must clear it without a clock edge
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset_done", int'(done), 0);

    // Reset 10 cycles into SCAN, then a full run on the same memory
    randomize_msg();
    model();
    load_mem();
    @(negedge clk);
    reset = 1'b0;
    repeat (11) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("midrun_done_low", int'(done), 0);
    chk("midrun_no_result_write", int'(dut.dm1.core[33]), 8'hEE);
    run("after_midrun", m_ctb, m_cto, m_cts);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
